// File: rtl/icache_refill_unit.sv
// ICache refill unit: takes one missing physical address at a time, issues a
// line-aligned read to memory, assembles the returned beats into a full line,
// then writes tag and data into a round-robin victim way.
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   miss_valid_i / miss_ready_o    miss handshake, miss_paddr_i is the address
//   mem_req_valid_o / _ready_i     memory read request, mem_req_addr_o is line aligned
//   mem_rsp_valid_i/_data_i/_error_i  response beats, ascending address, no backpressure
//   wr_en_o, wr_index_o, wr_way_o,
//   wr_tag_o, wr_data_o            one-cycle array write of the refilled line
//   refill_done_o, refill_err_o    completion pulses (err coincident with done)

package config_pkg;

  typedef struct packed {
    int unsigned PLEN;
    int unsigned ICACHE_BYTE_SIZE;
    int unsigned ICACHE_SET_ASSOC;
    int unsigned ICACHE_LINE_WIDTH;
  } user_cfg_t;

  typedef struct packed {
    int unsigned PLEN;
    int unsigned ICACHE_BYTE_SIZE;
    int unsigned ICACHE_SET_ASSOC;
    int unsigned ICACHE_LINE_WIDTH;
    int unsigned INDEX_WIDTH;
    int unsigned OFFSET_WIDTH;
    int unsigned TAG_WIDTH;
    int unsigned SET_ASSOC_WIDTH;
  } cfg_t;

  localparam user_cfg_t DefaultUserCfg = '{
    PLEN:              32,
    ICACHE_BYTE_SIZE:  4096,
    ICACHE_SET_ASSOC:  4,
    ICACHE_LINE_WIDTH: 256
  };

  function automatic cfg_t build_config(input user_cfg_t u);
    cfg_t        c;
    int unsigned line_bytes;
    int unsigned sets;
    c                   = '0;
    line_bytes          = u.ICACHE_LINE_WIDTH / 8;
    sets                = u.ICACHE_BYTE_SIZE / (u.ICACHE_SET_ASSOC * line_bytes);
    c.PLEN              = u.PLEN;
    c.ICACHE_BYTE_SIZE  = u.ICACHE_BYTE_SIZE;
    c.ICACHE_SET_ASSOC  = u.ICACHE_SET_ASSOC;
    c.ICACHE_LINE_WIDTH = u.ICACHE_LINE_WIDTH;
    c.OFFSET_WIDTH      = $clog2(line_bytes);
    c.INDEX_WIDTH       = $clog2(sets);
    c.TAG_WIDTH         = u.PLEN - c.INDEX_WIDTH - c.OFFSET_WIDTH;
    // A direct-mapped cache still carries a 1-bit way field (always 0).
    c.SET_ASSOC_WIDTH   = (u.ICACHE_SET_ASSOC > 1) ? $clog2(u.ICACHE_SET_ASSOC) : 1;
    return c;
  endfunction

endpackage

// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a miss; latches the address on miss_valid_i
// S_REQ   | memory read request held until mem_req_ready_i
// S_RECV  | collecting BEATS response beats into line_q, ORing errors
// S_WRITE | one cycle: array write (if no error) and completion pulses
module icache_refill_unit
  import config_pkg::*;
#(
  parameter cfg_t        Cfg    = build_config(DefaultUserCfg),
  parameter int unsigned MEM_DW = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             miss_valid_i,
  output logic                             miss_ready_o,
  input  logic [Cfg.PLEN-1:0]              miss_paddr_i,
  output logic                             mem_req_valid_o,
  input  logic                             mem_req_ready_i,
  output logic [Cfg.PLEN-1:0]              mem_req_addr_o,
  input  logic                             mem_rsp_valid_i,
  input  logic [MEM_DW-1:0]                mem_rsp_data_i,
  input  logic                             mem_rsp_error_i,
  output logic                             wr_en_o,
  output logic [Cfg.INDEX_WIDTH-1:0]       wr_index_o,
  output logic [Cfg.SET_ASSOC_WIDTH-1:0]   wr_way_o,
  output logic [Cfg.TAG_WIDTH-1:0]         wr_tag_o,
  output logic [Cfg.ICACHE_LINE_WIDTH-1:0] wr_data_o,
  output logic                             refill_done_o,
  output logic                             refill_err_o
);

  localparam int unsigned PLEN      = Cfg.PLEN;
  localparam int unsigned OFFSET    = Cfg.OFFSET_WIDTH;
  localparam int unsigned INDEX     = Cfg.INDEX_WIDTH;
  localparam int unsigned TAG       = Cfg.TAG_WIDTH;
  localparam int unsigned SA_W      = Cfg.SET_ASSOC_WIDTH;
  localparam int unsigned SET_ASSOC = Cfg.ICACHE_SET_ASSOC;
  localparam int unsigned LINE_W    = Cfg.ICACHE_LINE_WIDTH;
  localparam int unsigned BEATS     = LINE_W / MEM_DW;
  localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LAST_BEAT = BEATS - 1;

  localparam logic [PLEN-1:0] LINE_MASK = {{(PLEN-OFFSET){1'b1}}, {OFFSET{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_WRITE
  } state_e;

  state_e              state_q, state_d;
  logic [PLEN-1:0]     paddr_q, paddr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [BEAT_W-1:0]   cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [SA_W-1:0]     victim_q, victim_d;
  logic                miss_ready_q, miss_ready_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic                wr_en_q, wr_en_d;
  logic                refill_done_q, refill_done_d;
  logic                refill_err_q, refill_err_d;
  logic                beat_err;

  // Error status including the beat currently being accepted, so the final
  // beat's error is reflected in the WRITE-cycle pulses.
  assign beat_err = err_q | mem_rsp_error_i;

  always_comb begin
    state_d         = state_q;
    paddr_d         = paddr_q;
    line_d          = line_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    victim_d        = victim_q;
    wr_en_d         = 1'b0;
    refill_done_d   = 1'b0;
    refill_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (miss_valid_i) begin
          paddr_d = miss_paddr_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready_i) state_d = S_RECV;
      end
      S_RECV: begin
        if (mem_rsp_valid_i) begin
          line_d[cnt_q*MEM_DW +: MEM_DW] = mem_rsp_data_i;
          cnt_d = cnt_q + BEAT_W'(1);
          err_d = beat_err;
          if (cnt_q == BEAT_W'(LAST_BEAT)) begin
            state_d       = S_WRITE;
            wr_en_d       = ~beat_err;
            refill_done_d = 1'b1;
            refill_err_d  = beat_err;
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        // A failed refill leaves the victim pointer alone so the retry reuses the way.
        if (!err_q) begin
          victim_d = (victim_q == SA_W'(SET_ASSOC - 1)) ? '0 : victim_q + SA_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    miss_ready_d    = (state_d == S_IDLE);
    mem_req_valid_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      paddr_q         <= '0;
      line_q          <= '0;
      cnt_q           <= '0;
      err_q           <= 1'b0;
      victim_q        <= '0;
      miss_ready_q    <= 1'b1;
      mem_req_valid_q <= 1'b0;
      wr_en_q         <= 1'b0;
      refill_done_q   <= 1'b0;
      refill_err_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      paddr_q         <= paddr_d;
      line_q          <= line_d;
      cnt_q           <= cnt_d;
      err_q           <= err_d;
      victim_q        <= victim_d;
      miss_ready_q    <= miss_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      wr_en_q         <= wr_en_d;
      refill_done_q   <= refill_done_d;
      refill_err_q    <= refill_err_d;
    end
  end

  assign miss_ready_o    = miss_ready_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_addr_o  = paddr_q & LINE_MASK;
  assign wr_en_o         = wr_en_q;
  assign wr_index_o      = paddr_q[OFFSET +: INDEX];
  assign wr_tag_o        = paddr_q[PLEN-1 -: TAG];
  assign wr_way_o        = victim_q;
  assign wr_data_o       = line_q;
  assign refill_done_o   = refill_done_q;
  assign refill_err_o    = refill_err_q;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Self-checking bench for icache_refill_unit (default geometry: PLEN 32,
// 4 ways, 32 sets, 256-bit lines, 32-bit beats).
module tb_icache_refill_unit;
  import config_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid;
  logic         miss_ready;
  logic [31:0]  miss_paddr;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_data;
  logic         mem_rsp_error;
  logic         wr_en;
  logic [4:0]   wr_index;
  logic [1:0]   wr_way;
  logic [21:0]  wr_tag;
  logic [255:0] wr_data;
  logic         refill_done;
  logic         refill_err;

  always #5 clk = ~clk;

  icache_refill_unit dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .miss_valid_i    (miss_valid),
    .miss_ready_o    (miss_ready),
    .miss_paddr_i    (miss_paddr),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_addr_o  (mem_req_addr),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_data_i  (mem_rsp_data),
    .mem_rsp_error_i (mem_rsp_error),
    .wr_en_o         (wr_en),
    .wr_index_o      (wr_index),
    .wr_way_o        (wr_way),
    .wr_tag_o        (wr_tag),
    .wr_data_o       (wr_data),
    .refill_done_o   (refill_done),
    .refill_err_o    (refill_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endfunction

  // Stimulus for one refill
  logic [31:0] beat_data [8];
  int          gap_arr [8];
  int          err_beat;
  int          req_stall;
  bit          spurious;

  // Observations of one refill (times are cycles after the accepting edge T0)
  int           r_wr_t, r_wr_cnt, r_done_t, r_done_cnt, r_err_t, r_err_cnt, r_ready_t;
  logic [31:0]  r_addr;
  bit           r_addr_stable;
  logic [4:0]   r_index;
  logic [21:0]  r_tag;
  logic [1:0]   r_way;
  logic [255:0] r_data;

  // Reference model state: next victim way
  int model_way = 0;

  task automatic run_refill(input logic [31:0] paddr, input bit pre_accepted,
                            input bit hold_next, input logic [31:0] next_paddr);
    int stall_left, b, gap_left;
    bit in_beats, addr_seen;
    r_wr_t = -1; r_wr_cnt = 0; r_done_t = -1; r_done_cnt = 0;
    r_err_t = -1; r_err_cnt = 0; r_ready_t = -1;
    r_addr = '0; r_addr_stable = 1'b1; addr_seen = 1'b0;
    r_index = '0; r_tag = '0; r_way = '0; r_data = '0;
    if (!pre_accepted) begin
      for (int w = 0; w < 50; w++) begin
        @(negedge clk);
        if (miss_ready) break;
      end
      if (!miss_ready) chk("accept_timeout", 256'(miss_ready), 256'(1));
      miss_valid = 1'b1;
      miss_paddr = paddr;
      if (spurious) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_0001; mem_rsp_error = 1'b1;
      end
    end
    stall_left = req_stall; b = 0; gap_left = gap_arr[0]; in_beats = 1'b0;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      if (mem_req_valid) begin
        if (!addr_seen) begin r_addr = mem_req_addr; addr_seen = 1'b1; end
        else if (mem_req_addr !== r_addr) r_addr_stable = 1'b0;
      end
      if (miss_ready && r_ready_t < 0) r_ready_t = t;
      if (wr_en) begin
        r_wr_cnt++; r_wr_t = t;
        r_index = wr_index; r_tag = wr_tag; r_way = wr_way; r_data = wr_data;
      end
      if (refill_done) begin r_done_cnt++; r_done_t = t; end
      if (refill_err)  begin r_err_cnt++;  r_err_t = t;  end
      miss_valid    = hold_next;
      miss_paddr    = hold_next ? next_paddr : paddr;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_error = 1'b0;
      mem_rsp_data  = 32'h0;
      if (in_beats) begin
        if (b < 8) begin
          if (gap_left > 0) gap_left--;
          else begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = beat_data[b];
            mem_rsp_error = (b == err_beat);
            b++;
            if (b < 8) gap_left = gap_arr[b];
          end
        end
      end else if (mem_req_valid) begin
        if (stall_left > 0) begin
          stall_left--;
          if (spurious) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_0002; mem_rsp_error = 1'b1;
          end
        end else begin
          mem_req_ready = 1'b1;
          in_beats = 1'b1;
        end
      end
      if (r_done_t >= 0 && t > r_done_t) break;
    end
    if (r_done_t < 0) chk("done_timeout", 256'(0), 256'(1));
  endtask

  task automatic verify(input string nm, input logic [31:0] exp_addr, input logic [4:0] exp_index,
                        input logic [21:0] exp_tag, input int exp_way, input bit exp_err,
                        input int exp_lat);
    logic [255:0] exp_line;
    for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = beat_data[k];
    chk({nm, ".req_addr"},   r_addr, exp_addr);
    chk({nm, ".addr_stable"}, 256'(r_addr_stable), 256'(1));
    chk({nm, ".done_cnt"},   r_done_cnt, 1);
    chk({nm, ".done_t"},     r_done_t, exp_lat);
    chk({nm, ".ready_t"},    r_ready_t, exp_lat + 1);
    if (exp_err) begin
      chk({nm, ".wr_cnt"},   r_wr_cnt, 0);
      chk({nm, ".err_cnt"},  r_err_cnt, 1);
      chk({nm, ".err_t"},    r_err_t, exp_lat);
    end else begin
      chk({nm, ".wr_cnt"},   r_wr_cnt, 1);
      chk({nm, ".err_cnt"},  r_err_cnt, 0);
      chk({nm, ".wr_t"},     r_wr_t, exp_lat);
      chk({nm, ".index"},    r_index, exp_index);
      chk({nm, ".tag"},      r_tag, exp_tag);
      chk({nm, ".way"},      r_way, exp_way[1:0]);
      chk({nm, ".data"},     r_data, exp_line);
    end
  endtask

  typedef struct {
    logic [31:0] paddr;
    int          err_beat;
    int          stall;
    int          gap;
    bit          spur;
    logic [31:0] exp_addr;
    logic [4:0]  exp_index;
    logic [21:0] exp_tag;
    int          exp_way;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] pa, pb;
    int lat;
    bit e;

    vecs[0] = '{32'h8000_1234, -1, 0, 0, 1'b0, 32'h8000_1220, 5'h11, 22'h200004,  0, 1'b0, 10};
    vecs[1] = '{32'h0000_003F, -1, 0, 0, 1'b0, 32'h0000_0020, 5'h01, 22'h000000,  1, 1'b0, 10};
    vecs[2] = '{32'hFFFF_FFFF, -1, 0, 0, 1'b0, 32'hFFFF_FFE0, 5'h1F, 22'h3FFFFF,  2, 1'b0, 10};
    vecs[3] = '{32'h1234_5678, -1, 0, 0, 1'b0, 32'h1234_5660, 5'h13, 22'h048D15,  3, 1'b0, 10};
    vecs[4] = '{32'h0000_0400, -1, 0, 0, 1'b0, 32'h0000_0400, 5'h00, 22'h000001,  0, 1'b0, 10};
    vecs[5] = '{32'hA5A5_A5A5,  3, 0, 0, 1'b0, 32'hA5A5_A5A0, 5'h0D, 22'h296969,  1, 1'b1, 10};
    vecs[6] = '{32'hA5A5_A5A5, -1, 0, 0, 1'b0, 32'hA5A5_A5A0, 5'h0D, 22'h296969,  1, 1'b0, 10};
    vecs[7] = '{32'h8000_1234, -1, 5, 2, 1'b1, 32'h8000_1220, 5'h11, 22'h200004,  2, 1'b0, 29};

    rst = 1'b1; miss_valid = 1'b0; miss_paddr = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_error = 1'b0;
    err_beat = -1; req_stall = 0; spurious = 1'b0;
    for (int k = 0; k < 8; k++) gap_arr[k] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.miss_ready",  256'(miss_ready), 256'(1));
    chk("rst.req_valid",   256'(mem_req_valid), 256'(0));
    chk("rst.req_addr",    mem_req_addr, 0);
    chk("rst.wr_en",       256'(wr_en), 256'(0));
    chk("rst.done",        256'(refill_done), 256'(0));
    chk("rst.err",         256'(refill_err), 256'(0));
    chk("rst.wr_way",      wr_way, 0);
    chk("rst.wr_data",     wr_data, 0);
    rst = 1'b0;

    // Table: basic, round-robin 0,1,2,3,0, error keeps the way, stalls
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) begin
        beat_data[k] = 32'h1000_0000 + 32'(k) + (32'(i) << 20);
        gap_arr[k]   = (k == 0) ? 0 : vecs[i].gap;
      end
      err_beat = vecs[i].err_beat; req_stall = vecs[i].stall; spurious = vecs[i].spur;
      run_refill(vecs[i].paddr, 1'b0, 1'b0, 32'h0);
      verify($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_index, vecs[i].exp_tag,
             vecs[i].exp_way, vecs[i].exp_err, vecs[i].exp_lat);
      if (i == 0) begin
        chk("vec0.word0", r_data[31:0], 32'h1000_0000);
        chk("vec0.word7", r_data[255:224], 32'h1000_0007);
      end
      if (!vecs[i].exp_err) model_way = (model_way + 1) % 4;
    end

    // Busy backpressure: second miss held during the first refill
    err_beat = -1; req_stall = 0; spurious = 1'b0;
    for (int k = 0; k < 8; k++) begin beat_data[k] = 32'h2000_0000 + 32'(k); gap_arr[k] = 0; end
    pa = 32'h1111_1104; pb = 32'h2222_2233;
    run_refill(pa, 1'b0, 1'b1, pb);
    verify("busyA", pa & ~32'h1F, 5'((pa / 32) % 32), 22'(pa / 1024), model_way, 1'b0, 10);
    chk("busyA.ready_t11", r_ready_t, 11);
    model_way = (model_way + 1) % 4;
    run_refill(pb, 1'b1, 1'b0, 32'h0);
    verify("busyB", 32'h2222_2220, 5'((pb / 32) % 32), 22'(pb / 1024), model_way, 1'b0, 10);
    model_way = (model_way + 1) % 4;

    // Reset after beat 4 of a refill
    for (int w = 0; w < 50; w++) begin @(negedge clk); if (miss_ready) break; end
    miss_valid = 1'b1; miss_paddr = 32'h0BAD_F00D;
    @(negedge clk);
    miss_valid = 1'b0; mem_req_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h3000_0000 + 32'(k);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.miss_ready", 256'(miss_ready), 256'(1));
    chk("midrst.victim",     wr_way, 0);
    chk("midrst.req_valid",  256'(mem_req_valid), 256'(0));
    begin
      int seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (wr_en || refill_done) seen++;
      end
      chk("midrst.no_write", seen, 0);
    end
    model_way = 0;
    for (int k = 0; k < 8; k++) beat_data[k] = 32'h4000_0000 + 32'(k);
    run_refill(32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
    verify("postrst", 32'h0BAD_F000, 5'((32'h0BAD_F00D / 32) % 32), 22'(32'h0BAD_F00D / 1024),
           0, 1'b0, 10);
    model_way = 1;

    // Randomized refills against the reference model
    for (int i = 0; i < 20; i++) begin
      pa = $urandom;
      e = ($urandom_range(0, 3) == 0);
      err_beat = e ? int'($urandom_range(0, 7)) : -1;
      req_stall = $urandom_range(0, 3);
      spurious = $urandom_range(0, 1) == 1;
      lat = 10 + req_stall;
      for (int k = 0; k < 8; k++) begin
        beat_data[k] = $urandom;
        gap_arr[k] = $urandom_range(0, 2);
        lat += gap_arr[k];
      end
      run_refill(pa, 1'b0, 1'b0, 32'h0);
      verify($sformatf("rnd%0d", i), pa & ~32'h1F, 5'((pa / 32) % 32), 22'(pa / 1024),
             model_way, e, lat);
      if (!e) model_way = (model_way + 1) % 4;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/icache_refill_unit.md
# icache_refill_unit

Miss-handling stage directly downstream of the ICache lookup, sized entirely from `config_pkg::cfg_t` as produced by `build_config`. It accepts one missing physical address at a time and issues a single line-aligned read request to memory. It assembles the returned beats into a full cache line, then writes tag and data into the selected way of the ICache arrays. Victim way is chosen by an internal round-robin counter.

## Interface
Parameters:
- `Cfg`, default `build_config` of the default user config (PLEN 32, ICACHE_BYTE_SIZE 4096, ICACHE_SET_ASSOC 4, ICACHE_LINE_WIDTH 256, giving INDEX 5, OFFSET 5, TAG 22, SET_ASSOC_WIDTH 2). Supplies all cache geometry.
- `MEM_DW`, default 32. Memory response beat width. Must divide `Cfg.ICACHE_LINE_WIDTH`.
- `BEATS`, local, `ICACHE_LINE_WIDTH / MEM_DW`, default 8. `BEAT_W = $clog2(BEATS)`.

Ports:
- `clk_i` in 1: clock. Single clock domain.
- `rst_i` in 1: reset. Synchronous, active-high.
- `miss_valid_i` in 1: miss request valid.
- `miss_ready_o` out 1: unit idle and able to accept a miss.
- `miss_paddr_i` in PLEN: missing physical address. Low OFFSET bits are ignored.
- `mem_req_valid_o` out 1: memory read request valid.
- `mem_req_ready_i` in 1: memory accepts the request.
- `mem_req_addr_o` out PLEN: line-aligned address, low OFFSET bits zero.
- `mem_rsp_valid_i` in 1: one response beat valid. There is no backpressure.
- `mem_rsp_data_i` in MEM_DW: beat data.
- `mem_rsp_error_i` in 1: the beat carries a bus error.
- `wr_en_o` out 1: single-cycle array write strobe.
- `wr_index_o` out INDEX_WIDTH: set index.
- `wr_way_o` out SET_ASSOC_WIDTH: victim way.
- `wr_tag_o` out TAG_WIDTH: tag to write. Valid bit is implied set.
- `wr_data_o` out LINE_WIDTH: assembled line.
- `refill_done_o` out 1: one-cycle pulse when a refill finishes, on success or error.
- `refill_err_o` out 1: one-cycle pulse, coincident with `refill_done_o`, when any beat had an error.

## Operation
- FSM states: IDLE, REQ, RECV, WRITE.
- **IDLE**
  - `miss_ready_o=1`.
  - On `miss_valid_i`, latch the address into `paddr_q`, clear the beat counter and `err_q`, and go to REQ.
- **REQ**
  - `mem_req_valid_o=1`.
  - `mem_req_addr_o={paddr_q[PLEN-1:OFFSET], OFFSET'b0}`, held stable until the handshake.
  - On `mem_req_ready_i`, go to RECV.
- **RECV**
  - Each `mem_rsp_valid_i` beat writes `mem_rsp_data_i` into `line_q[cnt*MEM_DW +: MEM_DW]`.
  - Each beat increments `cnt` and ORs `mem_rsp_error_i` into `err_q`.
  - The beat received while `cnt==BEATS-1` moves the FSM to WRITE.
  - Beat order is ascending address; there is no critical-word-first.
- **WRITE** (one cycle)
  - `refill_done_o=1`.
  - If `err_q==0`:
    - `wr_en_o=1`.
    - `wr_index_o=paddr_q[OFFSET +: INDEX]`.
    - `wr_tag_o=paddr_q[PLEN-1 -: TAG]`.
    - `wr_way_o=victim_q`, `wr_data_o=line_q`.
    - `victim_q` increments modulo SET_ASSOC, wrapping 3 to 0.
  - If `err_q==1`:
    - `wr_en_o=0`, `refill_err_o=1`, and `victim_q` is unchanged.
  - Always returns to IDLE.
- `mem_rsp_valid_i` outside RECV is ignored and must not change `line_q`, `cnt` or `err_q`.
- Same-line misses are not merged; each accepted miss performs a full refill.
- With SET_ASSOC=1, `wr_way_o` is a 1-bit constant 0.

## Timing
- **Reset:**
  - State IDLE; `cnt=0`, `err_q=0`, `victim_q=0`.
  - Outputs after reset: `miss_ready_o=1`. All other 1-bit outputs are 0.
  - `mem_req_addr_o`, `wr_*` and `wr_data_o` are 0.
- **Reset mid-refill:** the next cycle is IDLE. The partial line is discarded, with no `wr_en_o` and no `refill_done_o`. A pending memory request is dropped.
- **Zero-wait latency:**
  - Miss accepted at edge T0.
  - REQ during T1, with the request handshake in T1.
  - Beats arrive in T2..T9.
  - WRITE in T10: `wr_en_o` and `refill_done_o` high.
  - IDLE in T11, so `miss_ready_o` is high again in T11.
- **Minimum spacing:** 11 cycles between accepted misses.
- **Stalls:** REQ holds indefinitely while `mem_req_ready_i=0`. Gaps between beats are allowed and add one cycle each.
- `miss_ready_o` is a registered state decode. It has no combinational path from `miss_valid_i`.
- `wr_*` outputs are meaningful only while `wr_en_o=1`. Outside that cycle they hold registered values and are not required to be 0.

## Test plan
- **Basic refill:**
  - Stimulus: miss paddr `0x8000_1234`; zero-wait memory returning beats `0x1000_0000+k` for k=0..7.
  - Required: `mem_req_addr_o=0x8000_1220`; `wr_index_o=0x11`; `wr_tag_o=0x200004`; `wr_way_o=0`.
  - Required: `wr_data_o[31:0]=0x1000_0000` and `wr_data_o[255:224]=0x1000_0007`.
  - Required: `wr_en_o` is high exactly at T10.
- **Round-robin:**
  - Stimulus: five back-to-back successful refills.
  - Required: `wr_way_o` sequence is 0,1,2,3,0.
- **Error beat:**
  - Stimulus: beat 3 has `mem_rsp_error_i=1`.
  - Required: `refill_done_o` and `refill_err_o` pulse together.
  - Required: `wr_en_o` stays 0.
  - Required: the next successful refill uses the same way as the failed one.
- **Stalls:**
  - Stimulus: `mem_req_ready_i` held low for 5 cycles; 2-cycle gaps between beats; spurious `mem_rsp_valid_i` in IDLE and REQ.
  - Required: `mem_req_addr_o` stays stable during the request stall.
  - Required: the line is correct and the spurious beats are ignored.
  - Required: `wr_en_o` occurs at T10 plus total stall cycles (5 + 7×2 = 19), i.e. at T29.
- **Reset mid-RECV:**
  - Stimulus: assert `rst_i` after beat 4.
  - Required: next cycle `miss_ready_o=1` and `victim_q=0`; no `wr_en_o` or `refill_done_o`.
  - Required: a new miss then completes normally.
- **Busy backpressure:**
  - Stimulus: `miss_valid_i` held high with a different address during a refill.
  - Required: `miss_ready_o=0` until T11.
  - Required: the second miss is accepted at T11 and its request issues with its own aligned address.
